// File: rtl/mnist_argmax_ctrl_if.sv
// Bundle of the controller's request, engine-side and result/statistics signals.
// master = the classification controller, slave = engine and result consumer.
interface mnist_argmax_ctrl_if #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
);
  logic                          go;
  logic [3:0]                    label;
  logic                          clr_stats;
  logic                          busy;
  logic                          eng_reset;
  logic                          eng_start;
  logic                          eng_done;
  logic [3:0]                    out_idx;
  logic signed [DATA_WIDTH-1:0]  out_data;
  logic                          res_valid;
  logic                          res_ready;
  logic [3:0]                    res_class;
  logic signed [DATA_WIDTH-1:0]  res_score;
  logic                          res_correct;
  logic                          res_timeout;
  logic [CNT_WIDTH-1:0]          total_cnt;
  logic [CNT_WIDTH-1:0]          correct_cnt;

  modport master (
    input  go, label, clr_stats, eng_done, out_data, res_ready,
    output busy, eng_reset, eng_start, out_idx, res_valid, res_class,
           res_score, res_correct, res_timeout, total_cnt, correct_cnt
  );

  modport slave (
    output go, label, clr_stats, eng_done, out_data, res_ready,
    input  busy, eng_reset, eng_start, out_idx, res_valid, res_class,
           res_score, res_correct, res_timeout, total_cnt, correct_cnt
  );
endinterface

// File: rtl/mnist_argmax_ctrl.sv
// Runs the inference engine, scans its ten scores for the argmax digit and
// reports it over a valid/ready result port while tracking accuracy counters.
module mnist_argmax_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT    = 65535
) (
  input logic                 clk,
  input logic                 rst,
  mnist_argmax_ctrl_if.master bus
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ENG_RST, ENG_START, WAIT_DONE, SCAN, RESULT
  } state_t;

  state_t                       state_q, state_d;
  logic [3:0]                   label_q, label_d;
  logic [TW-1:0]                tmo_q, tmo_d;
  logic [3:0]                   idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0] best_q, best_d;
  logic [3:0]                   best_idx_q, best_idx_d;
  logic [3:0]                   cls_q, cls_d;
  logic signed [DATA_WIDTH-1:0] score_q, score_d;
  logic                         correct_q, correct_d;
  logic                         timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]         total_q, total_d;
  logic [CNT_WIDTH-1:0]         ccnt_q, ccnt_d;
  logic                         enter_result;
  logic                         hit;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d      = state_q;
    label_d      = label_q;
    tmo_d        = tmo_q;
    idx_d        = idx_q;
    best_d       = best_q;
    best_idx_d   = best_idx_q;
    cls_d        = cls_q;
    score_d      = score_q;
    correct_d    = correct_q;
    timeout_d    = timeout_q;
    total_d      = total_q;
    ccnt_d       = ccnt_q;
    enter_result = 1'b0;
    hit          = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.go) begin
          label_d = bus.label;
          state_d = ENG_RST;
        end
      end
      ENG_RST:   state_d = ENG_START;
      ENG_START: begin
        tmo_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        tmo_d = tmo_q + 1'b1;
        if (bus.eng_done) begin
          idx_d   = 4'd0;
          state_d = SCAN;
        end else if (tmo_q == TMO_LAST) begin
          cls_d        = 4'd15;
          score_d      = '0;
          timeout_d    = 1'b1;
          enter_result = 1'b1;
          state_d      = RESULT;
        end
      end
      SCAN: begin
        // Strict compare: equal scores keep the earlier (lower) index.
        if (idx_q == 4'd0 || bus.out_data > best_q) begin
          best_d     = bus.out_data;
          best_idx_d = idx_q;
        end
        if (idx_q == 4'd9) begin
          idx_d        = 4'd0;
          cls_d        = best_idx_d;
          score_d      = best_d;
          timeout_d    = 1'b0;
          hit          = (best_idx_d == label_q);
          enter_result = 1'b1;
          state_d      = RESULT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      RESULT: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (enter_result) begin
      correct_d = hit;
      total_d   = sat_inc(total_q);
      if (hit) ccnt_d = sat_inc(ccnt_q);
    end
    if (bus.clr_stats) begin
      total_d = '0;
      ccnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      label_q    <= '0;
      tmo_q      <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      cls_q      <= '0;
      score_q    <= '0;
      correct_q  <= 1'b0;
      timeout_q  <= 1'b0;
      total_q    <= '0;
      ccnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      label_q    <= label_d;
      tmo_q      <= tmo_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      cls_q      <= cls_d;
      score_q    <= score_d;
      correct_q  <= correct_d;
      timeout_q  <= timeout_d;
      total_q    <= total_d;
      ccnt_q     <= ccnt_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.eng_reset   = (state_q == ENG_RST);
  assign bus.eng_start   = (state_q == ENG_START);
  assign bus.res_valid   = (state_q == RESULT);
  assign bus.out_idx     = idx_q;
  assign bus.res_class   = cls_q;
  assign bus.res_score   = score_q;
  assign bus.res_correct = correct_q;
  assign bus.res_timeout = timeout_q;
  assign bus.total_cnt   = total_q;
  assign bus.correct_cnt = ccnt_q;

endmodule

// File: tb/tb_mnist_argmax_ctrl.sv
// Directed and randomized classification runs against a behavioural argmax,
// timing and saturating-counter reference model.
module tb_mnist_argmax_ctrl;

  localparam int DW   = 12;
  localparam int CW   = 2;
  localparam int TMO  = 100;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mnist_argmax_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  mnist_argmax_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic signed [DW-1:0] sc [10];
  assign bus.out_data = (bus.out_idx < 4'd10) ? sc[bus.out_idx] : '0;

  int n_tests = 0;
  int n_fail  = 0;
  int m_total = 0;
  int m_correct = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, want);
    end
  endtask

  task automatic rand_scores();
    for (int i = 0; i < 10; i++) sc[i] = $signed(12'($urandom_range(0, 4095)));
  endtask

  // One classification. done_dly < 0: engine never finishes.
  // rst_scan >= 0: reset asserted in that SCAN cycle, run abandoned.
  task automatic run(input logic [3:0] lbl, input int done_dly, input int ready_dly,
                     input bit go_in_res, input int rst_scan, input bit clr_entry);
    int mx, e_cls, e_score;
    bit e_to, e_hit;
    e_to = (done_dly < 0);
    mx = sc[0];
    for (int i = 1; i < 10; i++) if (int'(sc[i]) > mx) mx = sc[i];
    e_cls = -1;
    for (int i = 9; i >= 0; i--) if (int'(sc[i]) == mx) e_cls = i;
    e_score = mx;
    if (e_to) begin e_cls = 15; e_score = 0; end
    e_hit = !e_to && (int'(lbl) == e_cls);

    @(negedge clk); bus.go = 1'b1; bus.label = lbl;
    @(negedge clk); bus.go = 1'b0; bus.label = 4'($urandom_range(0, 15));
    chk("eng_reset_pulse", bus.eng_reset, 1);
    chk("eng_start_low_n1", bus.eng_start, 0);
    chk("busy_rise", bus.busy, 1);
    bus.eng_done = 1'b0;
    @(negedge clk);
    chk("eng_start_pulse", bus.eng_start, 1);
    chk("eng_reset_low_n2", bus.eng_reset, 0);
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      chk("wait_quiet", {bus.eng_reset, bus.eng_start, bus.res_valid, bus.busy}, 4'b0001);
      if (k == done_dly) begin bus.eng_done = 1'b1; break; end
    end
    if (!e_to) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk("scan_idx", bus.out_idx, i);
        chk("scan_no_valid", bus.res_valid, 0);
        if (i == rst_scan) begin
          rst = 1'b0;
          @(negedge clk);
          rst = 1'b1;
          bus.eng_done = 1'b0;
          m_total = 0; m_correct = 0;
          chk("rst_ctrl_outs", {bus.busy, bus.eng_reset, bus.eng_start, bus.res_valid,
                                bus.res_correct, bus.res_timeout}, 0);
          chk("rst_out_idx", bus.out_idx, 0);
          chk("rst_res_class", bus.res_class, 0);
          chk("rst_res_score", bus.res_score, 0);
          chk("rst_counters", {bus.total_cnt, bus.correct_cnt}, 0);
          return;
        end
        if (i == 9 && clr_entry) bus.clr_stats = 1'b1;
      end
    end
    if (clr_entry) begin
      m_total = 0; m_correct = 0;
    end else begin
      if (m_total < CMAX) m_total++;
      if (e_hit && m_correct < CMAX) m_correct++;
    end
    @(negedge clk);
    bus.clr_stats = 1'b0;
    chk("res_valid_rise", bus.res_valid, 1);
    chk("res_class", bus.res_class, e_cls);
    chk("res_score", bus.res_score, e_score);
    chk("res_correct", bus.res_correct, e_hit);
    chk("res_timeout", bus.res_timeout, e_to);
    chk("total_cnt", bus.total_cnt, m_total);
    chk("correct_cnt", bus.correct_cnt, m_correct);
    chk("out_idx_back0", bus.out_idx, 0);
    for (int j = 0; j < ready_dly; j++) begin
      bus.go = go_in_res && (j % 3 == 0);
      @(negedge clk);
      chk("hold_valid", {bus.res_valid, bus.busy}, 2'b11);
      chk("hold_class", bus.res_class, e_cls);
      chk("hold_score", bus.res_score, e_score);
      chk("hold_flags", {bus.res_correct, bus.res_timeout}, {e_hit, e_to});
    end
    bus.res_ready = 1'b1;
    bus.go = go_in_res;
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.go = 1'b0;
    chk("valid_drop", bus.res_valid, 0);
    chk("busy_fall", bus.busy, 0);
    @(negedge clk);
    chk("go_ignored", {bus.busy, bus.eng_reset}, 0);
  endtask

  initial begin
    bus.go = 1'b0; bus.label = '0; bus.clr_stats = 1'b0;
    bus.eng_done = 1'b0; bus.res_ready = 1'b0;
    for (int i = 0; i < 10; i++) sc[i] = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {bus.busy, bus.eng_reset, bus.eng_start, bus.res_valid,
                       bus.res_correct, bus.res_timeout}, 0);
    chk("reset_idx_class", {bus.out_idx, bus.res_class}, 0);
    chk("reset_score", bus.res_score, 0);
    chk("reset_counters", {bus.total_cnt, bus.correct_cnt}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Tie between indices 2 and 7 at 100.
    sc[0] = -12'sd5;    sc[1] = 12'sd3;  sc[2] = 12'sd100; sc[3] = 12'sd7;
    sc[4] = -12'sd2048; sc[5] = 12'sd0;  sc[6] = 12'sd99;  sc[7] = 12'sd100;
    sc[8] = 12'sd1;     sc[9] = 12'sd2;
    run(4'd2, 50, 0, 1'b0, -1, 1'b0);

    for (int i = 0; i < 10; i++) sc[i] = -12'sd2048;
    run(4'd4, 3, 1, 1'b0, -1, 1'b0);

    rand_scores();
    run(4'($urandom_range(0, 9)), 7, 20, 1'b1, -1, 1'b0);

    run(4'd15, -1, 2, 1'b0, -1, 1'b0);

    rand_scores();
    run(4'd3, 5, 0, 1'b0, 5, 1'b0);
    run(4'd3, 5, 0, 1'b0, -1, 1'b0);

    bus.clr_stats = 1'b1;
    @(negedge clk);
    bus.clr_stats = 1'b0;
    m_total = 0; m_correct = 0;
    @(negedge clk);
    chk("clr_stats_idle", {bus.total_cnt, bus.correct_cnt}, 0);
    for (int r = 0; r < 5; r++) begin
      logic [3:0] l;
      l = 4'($urandom_range(0, 9));
      for (int i = 0; i < 10; i++) sc[i] = $signed(12'($urandom_range(0, 1000)));
      sc[l] = 12'sd2047;
      run(l, $urandom_range(0, 10), 0, 1'b0, -1, 1'b0);
    end
    chk("sat_total", bus.total_cnt, CMAX);
    chk("sat_correct", bus.correct_cnt, CMAX);
    rand_scores();
    run(4'($urandom_range(0, 9)), 4, 1, 1'b0, -1, 1'b1);

    for (int r = 0; r < 25; r++) begin
      rand_scores();
      if (r % 4 == 0) sc[$urandom_range(0, 9)] = sc[$urandom_range(0, 9)];
      run(4'($urandom_range(0, 11)), $urandom_range(0, 20), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), -1, (r % 9 == 8));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
